// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction-fetch sequencer.
//   fetch_state_t : sequencer state (IDLE after reset, RUN, HALTED)
//   npc_sel_t     : which source loads the program counter at the next edge
//   HALT_FILL     : bit replicated across the instruction width to form the
//                   halt word (all ones for any width)
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef enum logic [2:0] {
      NPC_HOLD  = 3'd0,
      NPC_INC   = 3'd1,
      NPC_ABS   = 3'd2,
      NPC_REL   = 3'd3,
      NPC_START = 3'd4
   } npc_sel_t;

   localparam logic HALT_FILL = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: free-standing statistics counter.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, clears the count
//   clr_i   : synchronous clear, wins over en_i
//   en_i    : increment this cycle (holds at all-ones once reached)
//   count_o : current count (registered)
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != {CW{1'b1}})) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the single-cycle core.
// Owns the program counter, addresses a combinational instruction ROM and
// hands the fetched word straight to the decoder in the same cycle. Stalls
// and branches decided this cycle take effect at the next rising edge. An
// all-ones word halts the sequencer; run statistics stay readable at Done.
//   Clk, Reset             : clock and asynchronous active-high reset
//   Start, StartAddr       : launch execution (accepted in IDLE/HALTED only)
//   Stall                  : datapath hold, PC and retired count frozen
//   BranchEn, BranchAbs    : take branch; absolute target or signed offset
//   Target                 : branch target / two's-complement offset
//   InstAddress, InstIn    : ROM address out, ROM data in
//   Inst, InstValid        : instruction to decoder and its qualifier
//   PC, Done               : program counter, high while halted
//   CycleCount, InstCount  : RUN cycles and retired instructions since Start
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int A  = 10,
   parameter int W  = 10,
   parameter int CW = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [A-1:0]  StartAddr,
   input  logic          Stall,
   input  logic          BranchEn,
   input  logic          BranchAbs,
   input  logic [A-1:0]  Target,
   output logic [A-1:0]  InstAddress,
   input  logic [W-1:0]  InstIn,
   output logic [W-1:0]  Inst,
   output logic          InstValid,
   output logic [A-1:0]  PC,
   output logic          Done,
   output logic [CW-1:0] CycleCount,
   output logic [CW-1:0] InstCount
);

   localparam logic [W-1:0] HALT_WORD = {W{HALT_FILL}};

   fetch_state_t state_q, state_d;
   logic [A-1:0] pc_q, pc_d;
   logic         done_q, done_d;

   npc_sel_t     npc_sel;
   logic         is_halt;
   logic         inst_valid;
   logic         cnt_clr;
   logic         cyc_en;
   logic         inst_en;

   logic signed [A:0] off_sext;
   logic        [A:0] rel_sum;
   logic      [A-1:0] pc_rel;

   assign is_halt = (InstIn == HALT_WORD);

   // Offset is widened by one bit before the add so the sign is explicit;
   // the carry-out is dropped, giving the modulo-2**A result.
   assign off_sext = {Target[A-1], Target};
   assign rel_sum  = {1'b0, pc_q} + $unsigned(off_sext);
   assign pc_rel   = rel_sum[A-1:0];

   always_comb begin
      state_d    = state_q;
      npc_sel    = NPC_HOLD;
      inst_valid = 1'b0;
      cnt_clr    = 1'b0;
      cyc_en     = 1'b0;
      inst_en    = 1'b0;

      case (state_q)
         IDLE, HALTED: begin
            if (Start) begin
               state_d = RUN;
               npc_sel = NPC_START;
               cnt_clr = 1'b1;
            end
         end

         RUN: begin
            cyc_en = 1'b1;
            if (is_halt) begin
               // Halt word wins over any stall or branch this cycle; the PC
               // stays on the halt address for the harness to read.
               state_d = HALTED;
            end else begin
               inst_valid = 1'b1;
               if (!Stall) begin
                  inst_en = 1'b1;
                  if (BranchEn) begin
                     npc_sel = BranchAbs ? NPC_ABS : NPC_REL;
                  end else begin
                     npc_sel = NPC_INC;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      case (npc_sel)
         NPC_INC:   pc_d = pc_q + A'(1);
         NPC_ABS:   pc_d = Target;
         NPC_REL:   pc_d = pc_rel;
         NPC_START: pc_d = StartAddr;
         default:   pc_d = pc_q;
      endcase
   end

   assign done_d = (state_d == HALTED);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
      end
   end

   sat_counter #(.CW(CW)) u_cycle_cnt (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .clr_i   (cnt_clr),
      .en_i    (cyc_en),
      .count_o (CycleCount)
   );

   sat_counter #(.CW(CW)) u_inst_cnt (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .clr_i   (cnt_clr),
      .en_i    (inst_en),
      .count_o (InstCount)
   );

   assign InstAddress = pc_q;
   assign Inst        = InstIn;
   assign InstValid   = inst_valid;
   assign PC          = pc_q;
   assign Done        = done_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   localparam int A  = 10;
   localparam int W  = 10;
   localparam int CW = 16;

   logic          Clk;
   logic          Reset;
   logic          Start;
   logic [A-1:0]  StartAddr;
   logic          Stall;
   logic          BranchEn;
   logic          BranchAbs;
   logic [A-1:0]  Target;
   logic [A-1:0]  InstAddress;
   logic [W-1:0]  InstIn;
   logic [W-1:0]  Inst;
   logic          InstValid;
   logic [A-1:0]  PC;
   logic          Done;
   logic [CW-1:0] CycleCount;
   logic [CW-1:0] InstCount;

   logic [W-1:0] rom [1024];

   int n_tests = 0;
   int n_fail  = 0;

   fetch_ctrl #(.A(A), .W(W), .CW(CW)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .StartAddr   (StartAddr),
      .Stall       (Stall),
      .BranchEn    (BranchEn),
      .BranchAbs   (BranchAbs),
      .Target      (Target),
      .InstAddress (InstAddress),
      .InstIn      (InstIn),
      .Inst        (Inst),
      .InstValid   (InstValid),
      .PC          (PC),
      .Done        (Done),
      .CycleCount  (CycleCount),
      .InstCount   (InstCount)
   );

   assign InstIn = rom[InstAddress];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 10'h001 + W'(i % 7);
      rom[4] = 10'h3FF;

      Reset     = 1'b1;
      Start     = 1'b0;
      StartAddr = '0;
      Stall     = 1'b0;
      BranchEn  = 1'b0;
      BranchAbs = 1'b0;
      Target    = '0;

      #2;
      chk("rst_pc",    32'(PC), 0);
      chk("rst_done",  32'(Done), 0);
      chk("rst_valid", 32'(InstValid), 0);
      chk("rst_cyc",   32'(CycleCount), 0);
      chk("rst_inst",  32'(InstCount), 0);
      #10;
      Reset = 1'b0;
      step();
      chk("idle_valid", 32'(InstValid), 0);

      // Straight-line run into the halt word at address 4
      Start = 1'b1; StartAddr = 10'd0;
      step();
      Start = 1'b0;
      chk("run0_pc",    32'(PC), 0);
      chk("run0_valid", 32'(InstValid), 1);
      chk("run0_inst",  32'(Inst), 32'(rom[0]));
      step(); chk("run1_pc", 32'(PC), 1);
      step(); chk("run2_pc", 32'(PC), 2);
      step(); chk("run3_pc", 32'(PC), 3);
      step();
      chk("run4_pc",    32'(PC), 4);
      chk("run4_valid", 32'(InstValid), 0);
      chk("run4_done",  32'(Done), 0);
      step();
      chk("halt_done", 32'(Done), 1);
      chk("halt_pc",   32'(PC), 4);
      chk("halt_cyc",  32'(CycleCount), 5);
      chk("halt_inst", 32'(InstCount), 4);
      step();
      chk("halt_hold_cyc", 32'(CycleCount), 5);

      // Relative and absolute branches
      Start = 1'b1; StartAddr = 10'd5;
      step();
      Start = 1'b0;
      chk("rs_pc",   32'(PC), 5);
      chk("rs_cyc",  32'(CycleCount), 0);
      chk("rs_done", 32'(Done), 0);
      BranchEn = 1'b1; BranchAbs = 1'b0; Target = 10'h3FE;
      step();
      chk("brel_pc", 32'(PC), 3);
      BranchAbs = 1'b1; Target = 10'd100;
      step();
      chk("babs_pc", 32'(PC), 100);
      Target = 10'd7;
      step();
      chk("b7_pc",   32'(PC), 7);
      chk("b7_cyc",  32'(CycleCount), 3);
      chk("b7_inst", 32'(InstCount), 3);

      // Three stalled cycles with a pending branch
      Stall = 1'b1; Target = 10'd50;
      step(); step(); step();
      chk("stall_pc",   32'(PC), 7);
      chk("stall_cyc",  32'(CycleCount), 6);
      chk("stall_inst", 32'(InstCount), 3);
      Stall = 1'b0; BranchEn = 1'b0;
      step();
      chk("unstall_pc",   32'(PC), 8);
      chk("unstall_inst", 32'(InstCount), 4);
      chk("unstall_cyc",  32'(CycleCount), 7);

      // Start during RUN has no effect
      Start = 1'b1; StartAddr = 10'd20;
      step();
      Start = 1'b0;
      chk("srun_pc",   32'(PC), 9);
      chk("srun_cyc",  32'(CycleCount), 8);
      chk("srun_inst", 32'(InstCount), 5);

      // Asynchronous reset between edges, with Start held high
      #3;
      Reset = 1'b1; Start = 1'b1; StartAddr = 10'd20;
      #1;
      chk("arst_pc",    32'(PC), 0);
      chk("arst_cyc",   32'(CycleCount), 0);
      chk("arst_inst",  32'(InstCount), 0);
      chk("arst_valid", 32'(InstValid), 0);
      step();
      Start = 1'b0; Reset = 1'b0;
      #1;
      chk("arst_idle_pc",    32'(PC), 0);
      chk("arst_idle_valid", 32'(InstValid), 0);
      step();
      chk("arst_idle2_valid", 32'(InstValid), 0);

      // Wrap from the top of the address space, then branch onto the halt word
      Start = 1'b1; StartAddr = 10'd1023;
      step();
      Start = 1'b0;
      chk("wrap_top_pc",    32'(PC), 1023);
      chk("wrap_top_valid", 32'(InstValid), 1);
      step();
      chk("wrap_pc", 32'(PC), 0);
      BranchEn = 1'b1; BranchAbs = 1'b1; Target = 10'd4;
      step();
      chk("bh_pc",    32'(PC), 4);
      chk("bh_valid", 32'(InstValid), 0);
      Target = 10'd50; Stall = 1'b1;
      step();
      BranchEn = 1'b0; Stall = 1'b0;
      chk("bh_done", 32'(Done), 1);
      chk("bh_pc2",  32'(PC), 4);
      chk("bh_cyc",  32'(CycleCount), 3);
      chk("bh_inst", 32'(InstCount), 2);

      // Restart from HALTED
      Start = 1'b1; StartAddr = 10'd20;
      step();
      Start = 1'b0;
      chk("rh_pc",    32'(PC), 20);
      chk("rh_cyc",   32'(CycleCount), 0);
      chk("rh_inst",  32'(InstCount), 0);
      chk("rh_done",  32'(Done), 0);
      chk("rh_valid", 32'(InstValid), 1);
      step();
      chk("rh_next_pc", 32'(PC), 21);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
